// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered, handshaked RV immediate generator with a two-entry skid buffer
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [2:0]            ImmSrc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ImmOp,
    output logic                  ImmIllegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH:0]   r0_q, r0_d;
    logic [DATA_WIDTH:0]   r1_q, r1_d;
    logic                  in_ready_q;

    logic [31:0]           imm32;
    logic                  illegal;
    logic [DATA_WIDTH:0]   entry;
    logic                  push;
    logic                  pop;
    logic                  unused_opcode;

    assign unused_opcode = ^instr[6:0];

    // Every format is built as a 32-bit value whose bit 31 carries the sign;
    // Z mode and illegal selects have bit 31 clear, so one sign extension covers all.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (ImmSrc)
            3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011:  imm32 = {instr[31:12], 12'b0};
            3'b100:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b101:  imm32 = {27'b0, instr[19:15]};
            default: illegal = 1'b1;
        endcase
    end

    assign entry = {illegal, DATA_WIDTH'($signed(imm32))};

    assign out_valid  = (state_q != EMPTY);
    assign in_ready   = in_ready_q;
    assign ImmOp      = r0_q[DATA_WIDTH-1:0];
    assign ImmIllegal = r0_q[DATA_WIDTH];

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    r0_d    = entry;
                end
            end
            ONE: begin
                if (push && pop) begin
                    r0_d = entry;
                end else if (push) begin
                    state_d = TWO;
                    r1_d    = entry;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    r0_d    = r1_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            r0_q       <= '0;
            r1_q       <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            in_ready_q <= (state_d != TWO);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed checks of imm_gen_pipe at 32 and 64 bits
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic        flush;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32_o;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64_o;

    int checks = 0;
    int errors = 0;

    logic [64:0] mq[$];
    logic [31:0] rcv[$];
    logic [31:0] stream[10];
    logic        m_pop, m_push;

    imm_gen_pipe #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .ImmSrc(ImmSrc), .flush(flush), .out_valid(out_valid32),
        .out_ready(out_ready), .ImmOp(imm32_o), .ImmIllegal(ill32)
    );

    imm_gen_pipe #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .ImmSrc(ImmSrc), .flush(flush), .out_valid(out_valid64),
        .out_ready(out_ready), .ImmOp(imm64_o), .ImmIllegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference immediate as a signed 64-bit value assembled with arithmetic shifts
    function automatic logic [64:0] ref_entry(input logic [31:0] ins, input logic [2:0] src);
        longint     s;
        longint     hi;
        logic [63:0] r;
        logic        ill;
        s   = longint'($signed(ins));
        ill = 1'b0;
        r   = '0;
        case (src)
            3'd0: r = s >>> 20;
            3'd1: begin
                hi = s >>> 25;
                r  = (hi << 5) | 64'(ins[11:7]);
            end
            3'd2: begin
                hi = s >>> 31;
                r  = (hi << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
            end
            3'd3: r = s & ~64'hFFF;
            3'd4: begin
                hi = s >>> 31;
                r  = (hi << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
            end
            3'd5: r = 64'(ins[19:15]);
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            m_pop  = (mq.size() > 0) && out_ready;
            m_push = in_valid && (mq.size() < 2);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(ref_entry(instr, ImmSrc));
        end
    end

    always @(negedge clk) begin
        chk("out_valid32", 64'(out_valid32), 64'(mq.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(mq.size() > 0));
        chk("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
        chk("in_ready64", 64'(in_ready64), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("imm32", 64'(imm32_o), 64'(mq[0][31:0]));
            chk("imm64", imm64_o, mq[0][63:0]);
            chk("ill32", 64'(ill32), 64'(mq[0][64]));
            chk("ill64", 64'(ill64), 64'(mq[0][64]));
        end
    end

    task automatic push_expect(input string nm, input logic [31:0] ins, input logic [2:0] src,
                               input logic [63:0] e64, input logic eill);
        in_valid = 1'b1;
        instr    = ins;
        ImmSrc   = src;
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_v"}, 64'(out_valid32), 64'd1);
        chk({nm, "_32"}, 64'(imm32_o), 64'(e64[31:0]));
        chk({nm, "_64"}, imm64_o, e64);
        chk({nm, "_ill"}, 64'(ill32), 64'(eill));
    endtask

    initial begin
        int         k;
        logic       acc;
        logic [31:0] held;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        instr = '0; ImmSrc = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready", 64'(in_ready32), 64'd1);
        chk("rst_imm32", 64'(imm32_o), 64'd0);
        chk("rst_imm64", imm64_o, 64'd0);
        chk("rst_ill", 64'(ill64), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        push_expect("sweep_I", 32'h80000000, 3'd0, 64'hFFFFFFFFFFFFF800, 1'b0);
        push_expect("sweep_S", 32'h80000000, 3'd1, 64'hFFFFFFFFFFFFF800, 1'b0);
        push_expect("sweep_B", 32'h80000000, 3'd2, 64'hFFFFFFFFFFFFF000, 1'b0);
        push_expect("sweep_U", 32'h80000000, 3'd3, 64'hFFFFFFFF80000000, 1'b0);
        push_expect("sweep_J", 32'h80000000, 3'd4, 64'hFFFFFFFFFFF00000, 1'b0);
        push_expect("pos_B", 32'h00000080, 3'd2, 64'h0000000000000800, 1'b0);
        push_expect("pos_J", 32'h00100000, 3'd4, 64'h0000000000000800, 1'b0);
        push_expect("pos_Z", 32'h000F8000, 3'd5, 64'h000000000000001F, 1'b0);
        push_expect("illegal6", 32'hFFFFFFFF, 3'd6, 64'h0, 1'b1);
        push_expect("illegal7", 32'h12345678, 3'd7, 64'h0, 1'b1);
        push_expect("neg_I", 32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            stream[i] = {12'(i * 37 + 5), 13'h0020, 7'h13};
        end
        rcv.delete();
        k   = 0;
        acc = 1'b0;
        held = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (acc) k++;
            out_ready = !(c >= 3 && c < 6);
            in_valid  = (k < 10);
            instr     = stream[(k < 10) ? k : 0];
            ImmSrc    = 3'd0;
            if (c == 4) begin
                chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
                chk("bp_held_count", 64'(k - rcv.size()), 64'd2);
                held = imm32_o;
            end
            if (c == 5 || c == 6) begin
                chk("bp_hold_imm", 64'(imm32_o), 64'(held));
                chk("bp_in_ready_still_low", 64'(in_ready32), 64'd0);
            end
            if (c == 7) chk("bp_recover", 64'(in_ready32), 64'd1);
            if (out_valid32 && out_ready) rcv.push_back(imm32_o);
            acc = in_valid && in_ready32;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(rcv.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < rcv.size()) chk("bp_order", 64'(rcv[i]), 64'(i * 37 + 5));
        end

        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00A00013; ImmSrc = 3'd0;
            if (t == 1) begin
                @(negedge clk);
                instr = 32'h00B00013;
            end
            @(negedge clk);
            chk("flush_pre_in_ready", 64'(in_ready32), 64'(t == 0));
            flush = 1'b1; in_valid = 1'b1; instr = 32'h7FF00013;
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            chk("flush_out_valid", 64'(out_valid32), 64'd0);
            chk("flush_in_ready", 64'(in_ready32), 64'd1);
            @(negedge clk);
            chk("flush_no_marker", 64'(out_valid64), 64'd0);
        end

        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00C00013; ImmSrc = 3'd0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid32", 64'(out_valid32), 64'd0);
        chk("arst_out_valid64", 64'(out_valid64), 64'd0);
        chk("arst_in_ready", 64'(in_ready32), 64'd1);
        chk("arst_imm64", imm64_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        push_expect("arst_first", 32'h12300013, 3'd0, 64'h0000000000000123, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = $urandom;
            ImmSrc    = 3'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
